// File: rtl/uart_rx_fifo_if.sv
// Core-side register interface of the UART receive FIFO: pop/clear strobes in,
// head data, occupancy and sticky error flags out.
interface uart_rx_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          read_req;
  logic          clr_err;
  logic [31:0]   rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overrun;
  logic          frame_err;

  modport master (
    output read_req, clr_err,
    input  rd_data, empty, full, count, overrun, frame_err
  );

  modport slave (
    input  read_req, clr_err,
    output rd_data, empty, full, count, overrun, frame_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 16x oversampling feeding a circular byte FIFO.
// The head entry is presented combinationally on rd_data; read_req pops it.
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned OVS      = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  uart_rx_fifo_if.slave  bus
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVS);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [3:0]  OS_LAST = 4'(OVS - 1);
  localparam logic [3:0]  OS_MID  = 4'(OVS / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      os_q, os_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tick;
  logic            stop_ok;
  logic            stop_bad;

  logic            rx_meta, rx_s, rx_prev;

  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic            empty, full;
  logic            push, pop, set_ovr;
  logic            overrun_q, frame_err_q;

  // Two-stage synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Receiver state, baud divider, oversample counter and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: frame sequencing on oversample ticks.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    os_d     = os_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    tick     = (div_q == DW'(DIV - 1));

    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + DW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (rx_prev && !rx_s) begin
          state_d = S_START;
          os_d    = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (os_q == OS_MID) begin
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              os_d    = '0;
              bit_d   = '0;
              state_d = S_DATA;
            end
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            shift_d = {rx_s, shift_q[7:1]};
            os_d    = '0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = S_STOP;
            end
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            if (rx_s) begin
              stop_ok = 1'b1;
              state_d = S_IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = S_BREAK;
            end
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      S_BREAK: begin
        if (tick && rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop while full frees the slot, so the incoming byte is still stored.
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = bus.read_req && !empty;
  assign push    = stop_ok && (!full || bus.read_req);
  assign set_ovr = stop_ok && full && !bus.read_req;

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= shift_q;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a set event takes priority over clr_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (set_ovr)          overrun_q <= 1'b1;
      else if (bus.clr_err) overrun_q <= 1'b0;
      if (stop_bad)         frame_err_q <= 1'b1;
      else if (bus.clr_err) frame_err_q <= 1'b0;
    end
  end

  assign bus.rd_data   = empty ? '1 : {24'h0, mem[rd_ptr]};
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;

endmodule
